cia_seq_addsub: RTL and testbench

Iterative, group-serial adder/subtractor built on the carry-increment group structure of the existing combinational carry-increment adder. It accepts one N-bit operation through a valid/ready handshake and processes one G-bit group per clock. It returns the result through a second valid/ready handshake. It is the sequential, subtract-capable counterpart of the combinational adder and is used where area matters more than latency.

---
 rtl/cia_pkg.sv | 21 ++
 rtl/cia_group.sv | 25 ++
 rtl/cia_seq_addsub.sv | 119 +++++++++++
 tb/tb_cia_seq_addsub.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cia_pkg.sv
// Shared types and sizing helpers for the group-serial
// carry-increment adder/subtractor.
package cia_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cia_state_t;

    // Group counter width; a single-group datapath still needs one bit.
    function automatic int cnt_width(input int n, input int g);
        int groups;
        groups = n / g;
        if (groups <= 1) begin
            return 1;
        end
        return $clog2(groups);
    endfunction

endpackage

// File: rtl/cia_group.sv
// Combinational G-bit carry-increment group: base sum plus its
// incremented copy, selected by the incoming carry.
module cia_group #(
    parameter int G = 8
) (
    input  logic [G-1:0] a_g,
    input  logic [G-1:0] b_g,
    input  logic         c,
    output logic [G-1:0] s,
    output logic         c_out
);

    logic [G:0]   w_base;
    logic [G-1:0] w_inc;
    logic         w_inc_c;

    assign w_base  = {1'b0, a_g} + {1'b0, b_g};
    assign w_inc   = w_base[G-1:0] + G'(1);
    // The increment only carries out when the base sum is all ones.
    assign w_inc_c = w_base[G] | (&w_base[G-1:0]);

    assign s     = c ? w_inc   : w_base[G-1:0];
    assign c_out = c ? w_inc_c : w_base[G];

endmodule

// File: rtl/cia_seq_addsub.sv
// Iterative adder/subtractor: one G-bit carry-increment group per
// clock, valid/ready handshake on both the request and the result.
module cia_seq_addsub
    import cia_pkg::*;
#(
    parameter int N = 64,
    parameter int G = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         cout,
    output logic         ovf
);

    localparam int NG = N / G;
    localparam int KW = cnt_width(N, G);
    localparam logic [KW-1:0] K_LAST = KW'(NG - 1);

    cia_state_t    r_state;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic          r_c;
    logic [KW-1:0] r_k;
    logic [N-1:0]  r_result;
    logic          r_cout;
    logic          r_ovf;
    logic          r_out_valid;

    logic [G-1:0]  w_a_g;
    logic [G-1:0]  w_b_g;
    logic [G-1:0]  w_s;
    logic          w_c;
    logic          w_last;
    logic          w_ovf;
    int            w_base;

    assign w_base = int'(r_k) * G;
    assign w_a_g  = r_a[w_base +: G];
    assign w_b_g  = r_b[w_base +: G];
    assign w_last = (r_k == K_LAST);

    // r_b already holds B', so both sign bits come straight from the latches.
    assign w_ovf = (r_a[N-1] == r_b[N-1]) & (w_s[G-1] != r_a[N-1]);

    cia_group #(
        .G (G)
    ) u_grp (
        .a_g   (w_a_g),
        .b_g   (w_b_g),
        .c     (r_c),
        .s     (w_s),
        .c_out (w_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= 1'b0;
            r_k         <= '0;
            r_result    <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_c     <= sub ^ cin;
                        r_k     <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_result[w_base +: G] <= w_s;
                    r_c <= w_c;
                    if (w_last) begin
                        r_cout      <= w_c;
                        r_ovf       <= w_ovf;
                        r_out_valid <= 1'b1;
                        r_k         <= '0;
                        r_state     <= DONE;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Held low while reset is asserted so nothing is accepted mid-reset.
    assign in_ready  = rst_n & (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_cia_seq_addsub.sv
// Self-checking bench for cia_seq_addsub (N=64, G=8).
module tb_cia_seq_addsub;

    localparam int N   = 64;
    localparam int G   = 8;
    localparam int LAT = N / G;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  result;
    logic          cout;
    logic          ovf;

    int n_cmp;
    int n_bad;
    int cyc;
    int acc_cyc;
    bit seen;
    logic [65:0] exp_q[$];
    int accs[$];

    cia_seq_addsub #(
        .N (N),
        .G (G)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Returns {ovf, cout, result} from plain integer arithmetic.
    function automatic logic [65:0] model(input logic [63:0] ma,
                                          input logic [63:0] mb,
                                          input logic mc,
                                          input logic ms);
        logic [64:0]        u;
        logic signed [66:0] w;
        logic signed [66:0] ea;
        logic signed [66:0] eb;
        logic signed [66:0] ec;
        logic               of;
        logic               co;
        ea = {{3{ma[63]}}, ma};
        eb = {{3{mb[63]}}, mb};
        ec = {66'd0, mc};
        if (ms) begin
            u = {1'b0, ma} - {1'b0, mb} - {64'd0, mc};
            w = ea - eb - ec;
            co = ~u[64];
        end else begin
            u = {1'b0, ma} + {1'b0, mb} + {64'd0, mc};
            w = ea + eb + ec;
            co = u[64];
        end
        of = !((w[66:63] == 4'b0000) || (w[66:63] == 4'b1111));
        return {of, co, u[63:0]};
    endfunction

    // Record accepted operations; reset discards anything in flight.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            cyc++;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                acc_cyc = cyc;
                accs.push_back(cyc);
                seen = 1'b0;
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_result", result, 0);
        end else begin
            chk("ready_valid_excl", in_ready & out_valid, 0);
            if (out_valid) begin
                chk("q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("m_result", result, exp_q[0][63:0]);
                    chk("m_cout", cout, exp_q[0][64]);
                    chk("m_ovf", ovf, exp_q[0][65]);
                end
                if (!seen) begin
                    chk("latency", cyc - acc_cyc, LAT);
                    seen = 1'b1;
                end
            end
        end
    end

    task automatic wait_ready(input string nm);
        int guard;
        guard = 0;
        while (!in_ready && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        chk({nm, "_in_ready"}, in_ready, 1);
    endtask

    task automatic wait_done(input string nm);
        int guard;
        guard = 0;
        while (!out_valid && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        chk({nm, "_out_valid"}, out_valid, 1);
    endtask

    task automatic do_op(input string nm,
                         input logic [63:0] ta, input logic [63:0] tb,
                         input logic tc, input logic ts,
                         input int hold, input bit scramble,
                         input logic [63:0] xr, input logic xc,
                         input logic xo);
        logic [63:0] snap;
        @(negedge clk);
        a = ta;
        b = tb;
        cin = tc;
        sub = ts;
        in_valid = 1'b1;
        wait_ready(nm);
        @(negedge clk);
        in_valid = 1'b0;
        if (scramble) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            cin = ~tc;
            sub = ~ts;
        end
        wait_done(nm);
        chk({nm, "_result"}, result, xr);
        chk({nm, "_cout"}, cout, xc);
        chk({nm, "_ovf"}, ovf, xo);
        snap = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, "_hold_result"}, result, snap);
            chk({nm, "_hold_in_ready"}, in_ready, 0);
            chk({nm, "_hold_valid"}, out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_post_valid"}, out_valid, 0);
        chk({nm, "_post_ready"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [65:0] m;
        int n0;
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        acc_cyc = 0;
        seen = 1'b1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;

        m = model(64'd1458996, 64'd8547441, 1'b0, 1'b0);
        chk("model_add", m, {2'b00, 64'd10006437});
        m = model(64'd8547441, 64'd1458996, 1'b1, 1'b1);
        chk("model_sub", m, {2'b01, 64'd7088444});
        m = model(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
        chk("model_ovf", m, {2'b11, 64'h7FFF_FFFF_FFFF_FFFF});

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_cout", cout, 0);
        chk("reset_ovf", ovf, 0);

        do_op("add", 64'd1458996, 64'd8547441, 1'b0, 1'b0, 0, 1'b0,
              64'd10006437, 1'b0, 1'b0);
        do_op("sub", 64'd8547441, 64'd1458996, 1'b0, 1'b1, 0, 1'b0,
              64'd7088445, 1'b1, 1'b0);
        do_op("sub_bin", 64'd8547441, 64'd1458996, 1'b1, 1'b1, 0, 1'b1,
              64'd7088444, 1'b1, 1'b0);
        do_op("carry_all", '1, 64'd0, 1'b1, 1'b0, 0, 1'b0,
              64'd0, 1'b1, 1'b0);
        do_op("borrow_all", 64'd0, 64'd1, 1'b0, 1'b1, 0, 1'b0,
              '1, 1'b0, 1'b0);
        do_op("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
              0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        do_op("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
              5, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

        // Back-to-back: the second request waits for the result handshake.
        n0 = accs.size();
        @(negedge clk);
        a = 64'd5;
        b = 64'd7;
        cin = 1'b1;
        sub = 1'b0;
        in_valid = 1'b1;
        wait_ready("b2b1");
        @(negedge clk);
        a = 64'd100;
        b = 64'd58;
        cin = 1'b0;
        sub = 1'b1;
        wait_done("b2b1");
        chk("b2b1_result", result, 64'd13);
        chk("b2b_single_acc", accs.size(), n0 + 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_two_acc", accs.size(), n0 + 2);
        if (accs.size() >= 2) begin
            chk("b2b_gap", accs[accs.size()-1] - accs[accs.size()-2],
                LAT + 2);
        end
        wait_done("b2b2");
        chk("b2b2_result", result, 64'd42);
        chk("b2b2_cout", cout, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of RUN (group 3) aborts the operation.
        @(negedge clk);
        a = '1;
        b = 64'h1234_5678_9ABC_DEF0;
        cin = 1'b0;
        sub = 1'b0;
        in_valid = 1'b1;
        wait_ready("abort");
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_cout", cout, 0);
        chk("abort_ovf", ovf, 0);
        chk("abort_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        do_op("fresh", 64'd1458996, 64'd8547441, 1'b0, 1'b0, 0, 1'b0,
              64'd10006437, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
